edge_event_arbiter: RTL and testbench

Multi-line event front end built on the posedge and one-cycle-pulse (010) detection scheme. Each of N input lines has its own detector, selectable per line. Detected events queue in a one-deep pending slot per line. A round-robin arbiter serialises them onto a single valid/ready event port, and a saturating counter records events lost to backpressure.

---
 rtl/edge_event_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Multi-line event front end. Each input line has its own edge detector,
// selectable per line between rising-edge detect and isolated one-cycle pulse
// (0-1-0) detect. A detected event waits in a one-deep pending slot for its
// line. A round-robin arbiter moves pending events, one per cycle, into a
// single valid/ready output slot. A saturating counter records events lost
// because a line's pending slot was still occupied.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active low
//   a          [N]     monitored input lines
//   mode       [N]     per line: 0 = rising edge, 1 = one-cycle pulse (010)
//   en         [N]     per line detection enable
//   evt_valid          output event present
//   evt_ready          consumer accepts event on evt_valid & evt_ready
//   evt_id     [ID_W]  line index of presented event
//   evt_kind           mode that was in force when the event was detected
//   drop_cnt   [CNT_W] saturating count of dropped events
//   clr_drop           synchronous clear of drop_cnt (wins over drops)
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter  int N     = 4,
  parameter  int CNT_W = 8,
  localparam int ID_W  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     mode,
  input  logic [N-1:0]     en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_kind,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             clr_drop
);

  // Wide enough for a saturated count plus a drop on every line at once.
  localparam int SUM_W = CNT_W + ID_W + 1;

  logic [N-1:0]     h1_q, h2_q;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     pend_kind_q, pend_kind_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             kind_q, kind_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [N-1:0]     det_pos, det_pls, det;
  logic [N-1:0]     gnt, drops;
  logic             load;
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  winner_nxt;
  logic [ID_W:0]    idx_w;
  logic [SUM_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  // ---------------------------------------------------------------------------
  // Detection
  // ---------------------------------------------------------------------------
  always_comb begin
    det_pos = a & ~h1_q;
    // Pulse flags on the cycle the line returns low after exactly one high.
    det_pls = ~a & h1_q & ~h2_q;
    det     = en & ((mode & det_pls) | (~mode & det_pos));
  end

  // ---------------------------------------------------------------------------
  // Round-robin winner search starting at rr_ptr
  // ---------------------------------------------------------------------------
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx_w  = '0;
    for (int k = 0; k < N; k++) begin
      idx_w = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx_w >= (ID_W+1)'(N)) begin
        idx_w = idx_w - (ID_W+1)'(N);
      end
      if (!found && pending_q[idx_w[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx_w[ID_W-1:0];
      end
    end
  end

  always_comb begin
    if (winner == ID_W'(N-1)) begin
      winner_nxt = '0;
    end else begin
      winner_nxt = winner + 1'b1;
    end
  end

  assign load = (~valid_q | evt_ready) & found;
  assign gnt  = load ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;

  // ---------------------------------------------------------------------------
  // Pending slots. A detection on a line whose slot is being granted this edge
  // refills the slot rather than dropping.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d   = pending_q;
    pend_kind_d = pend_kind_q;
    drops       = '0;
    for (int i = 0; i < N; i++) begin
      if (det[i] && (!pending_q[i] || gnt[i])) begin
        pending_d[i]   = 1'b1;
        pend_kind_d[i] = mode[i];
      end else if (gnt[i]) begin
        pending_d[i] = 1'b0;
      end
      drops[i] = det[i] & pending_q[i] & ~gnt[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Output slot and round-robin pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d  = valid_q;
    id_d     = id_q;
    kind_d   = kind_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      valid_d  = 1'b1;
      id_d     = winner;
      kind_d   = pend_kind_q[winner];
      rr_ptr_d = winner_nxt;
    end else if (evt_ready) begin
      valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating drop counter
  // ---------------------------------------------------------------------------
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + SUM_W'(drops[i]);
    end
    sum = SUM_W'(drop_q) + pop;
    if (clr_drop) begin
      drop_d = '0;
    end else if (sum > {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}}) begin
      drop_d = '1;
    end else begin
      drop_d = sum[CNT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1_q        <= '0;
      h2_q        <= '0;
      pending_q   <= '0;
      pend_kind_q <= '0;
      rr_ptr_q    <= '0;
      valid_q     <= 1'b0;
      id_q        <= '0;
      kind_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      h1_q        <= a;
      h2_q        <= h1_q;
      pending_q   <= pending_d;
      pend_kind_q <= pend_kind_d;
      rr_ptr_q    <= rr_ptr_d;
      valid_q     <= valid_d;
      id_q        <= id_d;
      kind_q      <= kind_d;
      drop_q      <= drop_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign evt_kind  = kind_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

  typedef struct {
    logic       rst_first;
    logic [3:0] a;
    logic [3:0] mode;
    logic [3:0] en;
    logic       rdy;
    logic       ev;
    logic [1:0] id;
    logic       kind;
    logic [7:0] drop;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, mode, en;
  logic       evt_ready, clr_drop;
  logic       evt_valid, evt_kind;
  logic [1:0] evt_id;
  logic [7:0] drop_cnt;
  logic       v2, k2;
  logic [1:0] id2;
  logic [1:0] drop2;

  int n_chk  = 0;
  int n_pass = 0;

  vec_t vecs[$];

  edge_event_arbiter dut (
    .clk(clk), .rst(rst), .a(a), .mode(mode), .en(en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_kind(evt_kind), .drop_cnt(drop_cnt), .clr_drop(clr_drop)
  );

  edge_event_arbiter #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .a(a), .mode(mode), .en(en),
    .evt_valid(v2), .evt_ready(evt_ready), .evt_id(id2),
    .evt_kind(k2), .drop_cnt(drop2), .clr_drop(clr_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; reset pulse stays clear of any clock edge.
  task automatic do_reset();
    a        = '0;
    clr_drop = 1'b0;
    rst      = 1'b0;
    #2;
    rst      = 1'b1;
  endtask

  function automatic void add(input logic rf, input logic [3:0] av, input logic [3:0] mv,
                              input logic [3:0] ev_en, input logic rdy, input logic ev,
                              input logic [1:0] id, input logic kind, input logic [7:0] drop);
    vec_t v;
    v.rst_first = rf;
    v.a         = av;
    v.mode      = mv;
    v.en        = ev_en;
    v.rdy       = rdy;
    v.ev        = ev;
    v.id        = id;
    v.kind      = kind;
    v.drop      = drop;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] pat;
    logic [16:0] em_pos, em_pls;
    logic        b;
    vec_t        v;
    int          exp_c2;

    rst = 1'b0; a = '0; mode = '0; en = '0; evt_ready = 1'b0; clr_drop = 1'b0;

    // Stimulus pattern, index 0 is the leftmost bit.
    pat    = 16'b1001011011110001;
    em_pos = '0;
    em_pos[1] = 1'b1; em_pos[4] = 1'b1; em_pos[6] = 1'b1; em_pos[9] = 1'b1; em_pos[16] = 1'b1;
    em_pls = '0;
    em_pls[2] = 1'b1; em_pls[5] = 1'b1;

    // Posedge mode on line 0.
    for (int k = 0; k < 17; k++) begin
      b = (k < 16) ? pat[15-k] : 1'b1;
      add(k == 0, {3'b000, b}, 4'b0000, 4'b0001, 1'b1, em_pos[k], 2'd0, 1'b0, 8'd0);
    end
    // Pulse mode on line 0.
    for (int k = 0; k < 17; k++) begin
      b = (k < 16) ? pat[15-k] : 1'b1;
      add(k == 0, {3'b000, b}, 4'b0001, 4'b0001, 1'b1, em_pls[k], 2'd0, 1'b1, 8'd0);
    end
    // Round robin across all four lines, then lines 1 and 3 after the wrap.
    add(1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    add(1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    add(1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 8'd0);
    add(1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0, 8'd0);
    add(1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0, 8'd0);
    add(1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b0, 8'd0);
    add(1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    add(1'b0, 4'b1010, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    add(1'b0, 4'b1010, 4'b0000, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0, 8'd0);
    add(1'b0, 4'b1010, 4'b0000, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b0, 8'd0);
    add(1'b0, 4'b1010, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);

    // Reset values.
    #12;
    chk("reset valid", evt_valid, 0);
    chk("reset id", evt_id, 0);
    chk("reset kind", evt_kind, 0);
    chk("reset drop", drop_cnt, 0);
    chk("reset drop c2", drop2, 0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.rst_first) do_reset();
      a = v.a; mode = v.mode; en = v.en; evt_ready = v.rdy;
      tick();
      chk($sformatf("vec%0d valid", i), evt_valid, v.ev);
      if (v.ev) begin
        chk($sformatf("vec%0d id", i), evt_id, v.id);
        chk($sformatf("vec%0d kind", i), evt_kind, v.kind);
      end
      chk($sformatf("vec%0d drop", i), drop_cnt, v.drop);
    end

    // Backpressure on line 2: slot holds, second rise pends, third drops.
    do_reset();
    en = 4'b0100; mode = 4'b0000; evt_ready = 1'b0;
    a = 4'b0100; tick(); chk("bp pend valid", evt_valid, 0);
    a = 4'b0000; tick(); chk("bp load valid", evt_valid, 1); chk("bp load id", evt_id, 2);
    a = 4'b0100; tick(); chk("bp hold valid", evt_valid, 1); chk("bp hold id", evt_id, 2);
    a = 4'b0000; tick(); chk("bp hold2 id", evt_id, 2); chk("bp no drop", drop_cnt, 0);
    a = 4'b0100; tick(); chk("bp drop", drop_cnt, 1); chk("bp hold3 id", evt_id, 2);
    a = 4'b0000; evt_ready = 1'b1;
    tick();
    chk("bp 2nd valid", evt_valid, 1); chk("bp 2nd id", evt_id, 2); chk("bp 2nd kind", evt_kind, 0);
    tick();
    chk("bp drained", evt_valid, 0); chk("bp drop kept", drop_cnt, 1);

    // Drop counter saturation on the 2-bit instance.
    do_reset();
    en = 4'b0001; mode = 4'b0000; evt_ready = 1'b0;
    a = 4'b0001; tick();
    a = 4'b0000; tick();
    a = 4'b0001; tick();
    for (int d = 1; d <= 5; d++) begin
      a = 4'b0000; tick();
      a = 4'b0001; tick();
      exp_c2 = (d > 3) ? 3 : d;
      chk($sformatf("sat c2 drop%0d", d), drop2, exp_c2);
      chk($sformatf("sat c8 drop%0d", d), drop_cnt, d);
    end
    a = 4'b0000; tick();
    a = 4'b0001; clr_drop = 1'b1; tick();
    chk("clr c2", drop2, 0); chk("clr c8", drop_cnt, 0);
    clr_drop = 1'b0;
    a = 4'b0000; tick();
    chk("clr hold c2", drop2, 0);

    // Asynchronous reset mid-cycle with a live slot and a nonzero count.
    a = 4'b0001; tick();
    chk("pre-rst valid", evt_valid, 1); chk("pre-rst drop", drop_cnt, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async valid", evt_valid, 0);
    chk("async drop", drop_cnt, 0);
    chk("async drop c2", drop2, 0);
    chk("async id", evt_id, 0);
    a = 4'b0001; en = 4'b0001; mode = 4'b0000; evt_ready = 1'b1;
    #1;
    rst = 1'b1;
    tick(); chk("post-rst pend", evt_valid, 0);
    tick(); chk("post-rst valid", evt_valid, 1); chk("post-rst id", evt_id, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post-rst quiet%0d", k), evt_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
